mem_port_arbiter: RTL

Arbitrates one shared memory port between the instruction-fetch (IF) requester and the load/store (LS) requester of the CPU datapath, so the core can run against a single-ported memory. It accepts one request at a time and drives it onto the memory bus until the memory acknowledges or a timeout expires. It then returns a one-cycle response to the requester that issued it. LS has priority over IF, bounded by a streak limit so fetch cannot starve.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and load/store (LS). LS wins ties until it has taken MAX_LS_STREAK grants
// in a row while IF waits. One transaction is in flight at a time. Each
// transaction ends on a memory ack or after TIMEOUT_CYCLES cycles.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LS_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_if_req,
  input  logic [DATA_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_gnt,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_err,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [DATA_WIDTH-1:0]   i_ls_addr,
  input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_be,
  output logic                    o_ls_gnt,
  output logic                    o_ls_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ls_rdata,
  output logic                    o_ls_err,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t                state_q, state_d;
  logic [STREAK_W-1:0]   ls_streak_q, ls_streak_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  if_gnt, ls_gnt;

  // Grants only in IDLE. LS wins a tie unless its streak is used up.
  // Grants are held off while reset is asserted.
  always_comb begin
    ls_gnt = 1'b0;
    if_gnt = 1'b0;
    if (state_q == IDLE && !i_reset) begin
      if (i_ls_req && (!i_if_req || ls_streak_q < STREAK_W'(MAX_LS_STREAK)))
        ls_gnt = 1'b1;
      else if (i_if_req)
        if_gnt = 1'b1;
    end
  end

  // Next state: latch payload on grant, finish on ack or timeout.
  // An ack takes priority over a timeout that falls in the same cycle.
  always_comb begin
    state_d     = state_q;
    ls_streak_d = ls_streak_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (ls_gnt) begin
          state_d     = BUSY_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = i_ls_we;
          mem_addr_d  = i_ls_addr;
          mem_wdata_d = i_ls_wdata;
          mem_be_d    = i_ls_be;
          if (ls_streak_q < STREAK_W'(MAX_LS_STREAK))
            ls_streak_d = ls_streak_q + 1'b1;
        end else if (if_gnt) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          ls_streak_d = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (i_mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          tmo_cnt_d   = '0;
          if_rvalid_d = (state_q == BUSY_IF);
          ls_rvalid_d = (state_q == BUSY_LS);
          rdata_d     = mem_we_q ? '0 : i_mem_rdata;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          tmo_cnt_d   = '0;
          if_rvalid_d = (state_q == BUSY_IF);
          ls_rvalid_d = (state_q == BUSY_LS);
          err_d       = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ls_streak_q <= '0;
      tmo_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ls_streak_q <= ls_streak_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_if_rvalid = if_rvalid_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_if_rdata  = if_rvalid_q ? rdata_q : '0;
  assign o_ls_rdata  = ls_rvalid_q ? rdata_q : '0;
  assign o_if_err    = if_rvalid_q & err_q;
  assign o_ls_err    = ls_rvalid_q & err_q;

endmodule
